// File: rtl/reorder_ctrl.sv
// Sequencing controller for the PCS RX lane-reorder datapath.
// It runs order discovery (clear the reorder table, then collect IDs under a
// programmable timeout). Once the order is locked, it strobes the swap-mux
// update and walks the round-robin lane select for the 66-bit serial output.
module reorder_ctrl #(
  parameter int N_LANES    = 20,
  parameter int NB_ID      = $clog2(N_LANES),
  parameter int NB_TIMEOUT = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_valid,
  input  logic                  i_deskew_done,
  input  logic                  i_rf_reset_order,
  input  logic                  i_reorder_ready,
  input  logic [NB_TIMEOUT-1:0] i_rf_timeout,
  output logic                  o_reset_order,
  output logic                  o_swap_update,
  output logic [NB_ID-1:0]      o_lane_sel,
  output logic                  o_data_valid,
  output logic                  o_locked,
  output logic                  o_timeout_err,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_COLLECT = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  localparam logic [NB_ID-1:0]      LAST_LANE    = NB_ID'(N_LANES - 1);
  localparam logic [NB_ID-1:0]      LANE_ONE     = NB_ID'(1);
  localparam logic [NB_TIMEOUT-1:0] CNT_MAX      = '1;
  localparam logic [NB_TIMEOUT-1:0] CNT_ONE      = NB_TIMEOUT'(1);
  localparam logic [NB_TIMEOUT:0]   CNT_WIDE_ONE = (NB_TIMEOUT + 1)'(1);

  state_t                  state_reg, state_next;
  logic [NB_TIMEOUT-1:0]   cnt_reg, cnt_next;
  logic [NB_ID-1:0]        lane_sel_reg, lane_sel_next;
  logic                    reset_order_reg, reset_order_next;
  logic                    swap_update_reg, swap_update_next;
  logic                    data_valid_reg, data_valid_next;
  logic                    timeout_err_reg, timeout_err_next;
  logic                    locked_reg;
  logic                    deskew_prev_reg;

  logic                    qualified;
  logic                    deskew_rise;
  logic [NB_TIMEOUT:0]     cnt_inc;
  logic                    timeout_hit;

  assign qualified   = i_enable && i_valid;
  assign deskew_rise = i_deskew_done && !deskew_prev_reg;
  // One bit wider so a saturated counter can never alias onto a timeout value.
  assign cnt_inc     = {1'b0, cnt_reg} + CNT_WIDE_ONE;
  assign timeout_hit = (i_rf_timeout != '0) && (cnt_inc == {1'b0, i_rf_timeout});

  // Next-state and next-output decode; everything holds on non-qualified cycles
  // except the data-valid strobe, which is only high after a qualified LOCKED cycle.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    lane_sel_next    = lane_sel_reg;
    reset_order_next = reset_order_reg;
    swap_update_next = swap_update_reg;
    data_valid_next  = 1'b0;
    timeout_err_next = timeout_err_reg;

    if (qualified) begin
      reset_order_next = 1'b0;
      swap_update_next = 1'b0;
      if (i_rf_reset_order) begin
        timeout_err_next = 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (deskew_rise || i_rf_reset_order) begin
            state_next       = ST_CLEAR;
            reset_order_next = 1'b1;
            cnt_next         = '0;
          end
        end

        ST_CLEAR: begin
          cnt_next   = '0;
          state_next = i_deskew_done ? ST_COLLECT : ST_IDLE;
        end

        ST_COLLECT: begin
          if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_ONE;
          end
          if (!i_deskew_done) begin
            state_next = ST_IDLE;
          end else if (i_rf_reset_order) begin
            state_next       = ST_CLEAR;
            reset_order_next = 1'b1;
            cnt_next         = '0;
          end else if (i_reorder_ready) begin
            state_next       = ST_LOCKED;
            swap_update_next = 1'b1;
            lane_sel_next    = '0;
          end else if (timeout_hit) begin
            // Flag the timeout and retry discovery from a fresh table.
            timeout_err_next = 1'b1;
            state_next       = ST_CLEAR;
            reset_order_next = 1'b1;
            cnt_next         = '0;
          end
        end

        ST_LOCKED: begin
          if (!i_deskew_done) begin
            state_next    = ST_IDLE;
            lane_sel_next = '0;
          end else if (i_rf_reset_order) begin
            state_next       = ST_CLEAR;
            reset_order_next = 1'b1;
            cnt_next         = '0;
          end else begin
            // Losing reorder_ready here is deliberately ignored.
            data_valid_next = 1'b1;
            lane_sel_next   = (lane_sel_reg == LAST_LANE) ? '0 : lane_sel_reg + LANE_ONE;
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and all outputs are registered; reset is synchronous.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      lane_sel_reg    <= '0;
      reset_order_reg <= 1'b0;
      swap_update_reg <= 1'b0;
      data_valid_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
      locked_reg      <= 1'b0;
      // Track the level through reset so a deskew_done held across reset
      // does not look like a fresh rising edge afterwards.
      deskew_prev_reg <= i_deskew_done;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      lane_sel_reg    <= lane_sel_next;
      reset_order_reg <= reset_order_next;
      swap_update_reg <= swap_update_next;
      data_valid_reg  <= data_valid_next;
      timeout_err_reg <= timeout_err_next;
      locked_reg      <= (state_next == ST_LOCKED);
      if (qualified) begin
        deskew_prev_reg <= i_deskew_done;
      end
    end
  end

  assign o_reset_order = reset_order_reg;
  assign o_swap_update = swap_update_reg;
  assign o_lane_sel    = lane_sel_reg;
  assign o_data_valid  = data_valid_reg;
  assign o_locked      = locked_reg;
  assign o_timeout_err = timeout_err_reg;
  assign o_state       = state_reg;

endmodule

// File: tb/tb_reorder_ctrl.sv
// Testbench for reorder_ctrl: a directed vector table, hand-written
// multi-cycle sequences, and random stimulus checked against a behavioural model.
module tb_reorder_ctrl;

  localparam int N_LANES    = 20;
  localparam int NB_ID      = 5;
  localparam int NB_TIMEOUT = 16;
  localparam logic [11:0] ALL = 12'hFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n, en, vld, dsk, rfro, rdy;
  logic [NB_TIMEOUT-1:0] tmo;
  logic                  o_reset_order, o_swap_update, o_data_valid, o_locked, o_timeout_err;
  logic [NB_ID-1:0]      o_lane_sel;
  logic [1:0]            o_state;

  reorder_ctrl #(
    .N_LANES(N_LANES), .NB_ID(NB_ID), .NB_TIMEOUT(NB_TIMEOUT)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_valid(vld),
    .i_deskew_done(dsk), .i_rf_reset_order(rfro), .i_reorder_ready(rdy),
    .i_rf_timeout(tmo),
    .o_reset_order(o_reset_order), .o_swap_update(o_swap_update),
    .o_lane_sel(o_lane_sel), .o_data_valid(o_data_valid), .o_locked(o_locked),
    .o_timeout_err(o_timeout_err), .o_state(o_state)
  );

  // Packed observation: {state[1:0], reset_order, swap_update, locked, lane[4:0], data_valid, timeout_err}
  logic [11:0] outs;
  assign outs = {o_state, o_reset_order, o_swap_update, o_locked, o_lane_sel, o_data_valid, o_timeout_err};

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [11:0] mk(int st, bit ro, bit su, bit lk, int lane, bit dv, bit err);
    logic [1:0] s;
    logic [4:0] l;
    s = st[1:0];
    l = lane[4:0];
    return {s, ro, su, lk, l, dv, err};
  endfunction

  task automatic check(input string name, input logic [11:0] exp, input logic [11:0] mask);
    n_checks++;
    if ((((outs ^ exp) & mask) == 12'h000) && !$isunknown(outs & mask))
      n_pass++;
    else
      $display("FAIL %s: actual=%03h required=%03h mask=%03h @%0t", name, outs, exp, mask, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Behavioural reference: discovery rules stated as a count of COLLECT cycles
  // since the last table clear, plus a lane position modulo N_LANES.
  int m_state, m_seen, m_lane, m_nxt;
  bit m_ro, m_su, m_dv, m_err, m_prev, m_go;
  int m_collect_cycles;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = 0; m_collect_cycles = 0; m_lane = 0;
      m_ro = 0; m_su = 0; m_dv = 0; m_err = 0; m_prev = dsk;
    end else begin
      m_dv = 0;
      if (en && vld) begin
        m_ro = 0; m_su = 0; m_go = 0; m_nxt = m_state;
        if (rfro) m_err = 0;
        case (m_state)
          0: if ((dsk && !m_prev) || rfro) m_go = 1;
          1: begin
            m_collect_cycles = 0;
            m_nxt = dsk ? 2 : 0;
          end
          2: begin
            m_seen = m_collect_cycles + 1;
            if (!dsk) m_nxt = 0;
            else if (rfro) m_go = 1;
            else if (rdy) begin m_nxt = 3; m_su = 1; m_lane = 0; end
            else if (tmo != 0 && m_seen == int'(tmo)) begin m_err = 1; m_go = 1; end
            m_collect_cycles = (m_seen > 65535) ? 65535 : m_seen;
          end
          default: begin
            if (!dsk) begin m_nxt = 0; m_lane = 0; end
            else if (rfro) m_go = 1;
            else begin m_dv = 1; m_lane = (m_lane + 1) % N_LANES; end
          end
        endcase
        if (m_go) begin m_nxt = 1; m_ro = 1; m_collect_cycles = 0; end
        m_prev  = dsk;
        m_state = m_nxt;
      end
    end
  end

  typedef struct {
    bit          rst_n, en, vld, dsk, rfro, rdy;
    logic [15:0] tmo;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int k;
    int n;
    bit err_exp;

    rst_n = 0; en = 1; vld = 1; dsk = 0; rfro = 0; rdy = 0; tmo = '0;

    // Bring-up: reset, deskew edge, collect, lock, then a few locked cycles.
    tbl[0]  = '{0, 1, 1, 0, 0, 0, 16'd0, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{0, 1, 1, 0, 0, 0, 16'd0, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{0, 1, 1, 0, 0, 0, 16'd0, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{1, 1, 1, 1, 0, 0, 16'd0, mk(1, 1, 0, 0, 0, 0, 0)};
    tbl[4]  = '{1, 1, 1, 1, 0, 0, 16'd0, mk(2, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{1, 1, 1, 1, 0, 0, 16'd0, mk(2, 0, 0, 0, 0, 0, 0)};
    tbl[6]  = '{1, 1, 1, 1, 0, 0, 16'd0, mk(2, 0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{1, 1, 1, 1, 0, 1, 16'd0, mk(3, 0, 1, 1, 0, 0, 0)};
    tbl[8]  = '{1, 1, 1, 1, 0, 0, 16'd0, mk(3, 0, 0, 1, 1, 1, 0)};
    tbl[9]  = '{1, 1, 0, 1, 0, 0, 16'd0, mk(3, 0, 0, 1, 1, 0, 0)};
    tbl[10] = '{1, 1, 1, 1, 0, 0, 16'd0, mk(3, 0, 0, 1, 2, 1, 0)};
    tbl[11] = '{1, 0, 1, 1, 0, 0, 16'd0, mk(3, 0, 0, 1, 2, 0, 0)};
    tbl[12] = '{1, 1, 1, 1, 1, 0, 16'd0, mk(1, 1, 0, 0, 2, 0, 0)};
    tbl[13] = '{1, 1, 1, 1, 0, 0, 16'd0, mk(2, 0, 0, 0, 2, 0, 0)};
    tbl[14] = '{1, 1, 1, 0, 0, 0, 16'd0, mk(0, 0, 0, 0, 2, 0, 0)};

    for (int i = 0; i < 15; i++) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en; vld = tbl[i].vld; dsk = tbl[i].dsk;
      rfro = tbl[i].rfro; rdy = tbl[i].rdy; tmo = tbl[i].tmo;
      tick();
      check($sformatf("vec%0d", i), tbl[i].exp, ALL);
      $display("vector %0d: outs=%03h", i, outs);
    end
    en = 1; vld = 1; rfro = 0; rdy = 0;

    // Lane walk in LOCKED with a toggling valid.
    dsk = 1; tick(); check("walk_clear", mk(1, 1, 0, 0, 0, 0, 0), 12'hF83);
    tick(); check("walk_collect", mk(2, 0, 0, 0, 0, 0, 0), 12'hF83);
    rdy = 1; tick(); check("walk_lock", mk(3, 0, 1, 1, 0, 0, 0), ALL);
    rdy = 0;
    k = 0;
    for (int c = 0; c < 45; c++) begin
      vld = (c % 2 == 0);
      tick();
      if (vld) k++;
      check("lane_walk", mk(3, 0, 0, 1, k % N_LANES, vld, 0), ALL);
    end
    $display("lane walk: %0d valid words, final lane=%0d", k, o_lane_sel);
    vld = 1;

    // Deskew loss in LOCKED, then a new deskew edge restarts discovery.
    dsk = 0; tick(); check("locked_deskew_fall", mk(0, 0, 0, 0, 0, 0, 0), ALL);
    dsk = 1; tick(); check("redeskew_clear", mk(1, 1, 0, 0, 0, 0, 0), ALL);
    tick(); check("redeskew_collect", mk(2, 0, 0, 0, 0, 0, 0), ALL);
    $display("deskew drop/restart sequence done");

    // Timeout retry loop with timeout=8.
    tmo = 16'd8;
    rfro = 1; tick(); check("tmo_restart", mk(1, 1, 0, 0, 0, 0, 0), ALL);
    rfro = 0;
    for (int rep = 0; rep < 3; rep++) begin
      err_exp = (rep > 0);
      tick(); check("tmo_clear_cycle", mk(2, 0, 0, 0, 0, 0, err_exp), ALL);
      for (int j = 1; j <= 8; j++) begin
        tick();
        if (j < 8) check("tmo_wait", mk(2, 0, 0, 0, 0, 0, err_exp), ALL);
        else       check("tmo_fire", mk(1, 1, 0, 0, 0, 0, 1), ALL);
      end
      $display("timeout round %0d done", rep);
    end
    // Timeout coinciding with rf_reset_order: the clear wins.
    tick(); check("tmo_race_collect", mk(2, 0, 0, 0, 0, 0, 1), ALL);
    for (int j = 1; j <= 8; j++) begin
      if (j == 8) rfro = 1;
      tick();
      if (j < 8) check("tmo_race_wait", mk(2, 0, 0, 0, 0, 0, 1), ALL);
      else       check("tmo_race_clear_wins", mk(1, 1, 0, 0, 0, 0, 0), ALL);
    end
    rfro = 0;
    // Lowering the timeout below the running count suppresses it; raising it re-arms.
    tick();
    for (int j = 0; j < 5; j++) tick();
    tmo = 16'd5;
    for (int j = 0; j < 4; j++) begin
      tick(); check("tmo_lowered", mk(2, 0, 0, 0, 0, 0, 0), ALL);
    end
    tmo = 16'd11;
    tick(); check("tmo_raised_wait", mk(2, 0, 0, 0, 0, 0, 0), ALL);
    tick(); check("tmo_raised_fire", mk(1, 1, 0, 0, 0, 0, 1), ALL);
    $display("timeout change sequence done");

    // Timeout disabled: long COLLECT, counter must saturate rather than wrap.
    tmo = 16'd0;
    rfro = 1; tick(); check("sat_enter", mk(2, 0, 0, 0, 0, 0, 0), ALL);
    rfro = 0;
    n = 0;
    for (int c = 0; c < 70000; c++) begin
      tick();
      n++;
      if (c % 10000 == 9999) check("sat_hold", mk(2, 0, 0, 0, 0, 0, 0), ALL);
    end
    tmo = 16'((n % 65536) + 1);
    tick(); check("sat_no_wrap", mk(2, 0, 0, 0, 0, 0, 0), ALL);
    tmo = 16'hFFFF;
    tick(); check("sat_no_fire_max", mk(2, 0, 0, 0, 0, 0, 0), ALL);
    tmo = 16'd0;
    $display("saturation sequence done after %0d collect cycles", n);

    // Reset mid-COLLECT with deskew held high: no restart until rf_reset_order.
    rst_n = 0; tick(); check("rst_mid_collect", mk(0, 0, 0, 0, 0, 0, 0), ALL);
    rst_n = 1;
    for (int j = 0; j < 5; j++) begin
      tick(); check("rst_held_deskew", mk(0, 0, 0, 0, 0, 0, 0), ALL);
    end
    rfro = 1; tick(); check("rst_rf_restart", mk(1, 1, 0, 0, 0, 0, 0), ALL);
    rfro = 0;
    $display("reset-held-deskew sequence done");

    // Random stimulus against the reference model.
    rst_n = 0; tick(); tick();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      en    = ($urandom_range(0, 9) != 0);
      vld   = ($urandom_range(0, 3) != 0);
      if (dsk ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 7) == 0)) dsk = ~dsk;
      rfro  = ($urandom_range(0, 39) == 0);
      rdy   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) tmo = 16'($urandom_range(0, 12));
      tick();
      check("random", mk(m_state, m_ro, m_su, (m_state == 3), m_lane, m_dv, m_err), ALL);
    end
    $display("random phase done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
